alu_ex_stage: RTL and testbench

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

---
 rtl/alu_ex_stage.sv | 213 +++++++++++++++++++++
 tb/tb_alu_ex_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-cycle shift-add unsigned multiplier.
// One operation in flight; in_ready drops while a multiply iterates.
module alu_ex_stage #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_dec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  output logic [WIDTH-1:0] ans_ex,
  output logic [3:0]       flag_ex,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] DM_data
);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_MOV = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b000101;
  localparam logic [5:0] OP_XOR = 6'b000110;
  localparam logic [5:0] OP_NOT = 6'b000111;
  localparam logic [5:0] OP_SLL = 6'b011001;
  localparam logic [5:0] OP_SRL = 6'b011010;
  localparam logic [5:0] OP_SRA = 6'b011011;
  localparam logic [5:0] OP_IN  = 6'b010110;
  localparam logic [5:0] OP_OUT = 6'b010111;
  localparam logic [5:0] OP_MUL = 6'b100000;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   ans_q, ans_d;
  logic [3:0]         flag_q, flag_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [WIDTH-1:0]   dm_q, dm_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW:0]       cnt_q, cnt_d;

  logic               fire;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_sum;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_w, sub_w, sll_w, srl_w, sra_w;
  logic signed [WIDTH:0] sra_src;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_nz, alu_wr;
  logic [3:0]         alu_flags;

  assign in_ready = (state_q == S_IDLE);
  assign fire     = in_valid & in_ready;

  // Shifts carry one extra bit so the last bit shifted out falls into it (0 for a zero shift).
  assign shamt   = B[SHW-1:0];
  assign add_w   = {1'b0, A} + {1'b0, B};
  assign sub_w   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign sll_w   = {1'b0, A} << shamt;
  assign srl_w   = {A, 1'b0} >> shamt;
  assign sra_src = {A, 1'b0};
  assign sra_w   = sra_src >>> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_nz  = 1'b1;
    alu_wr  = 1'b1;
    case (op_dec)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MOV: alu_res = B;
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~B;
      OP_SLL: begin
        alu_res = sll_w[WIDTH-1:0];
        alu_c   = sll_w[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_w[WIDTH:1];
        alu_c   = srl_w[0];
      end
      OP_SRA: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      OP_IN:  alu_res = data_in;
      OP_OUT, OP_MUL,
      6'b011100, 6'b011101, 6'b011110, 6'b011111: alu_wr = 1'b0;
      default: alu_nz = 1'b0;
    endcase
  end

  assign alu_flags = {alu_nz & alu_res[WIDTH-1], alu_nz & (alu_res == '0), alu_c, alu_v};

  assign mul_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_LAST);
  assign mul_step = (state_q == S_MUL) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fire && op_dec == OP_MUL) state_d = S_MUL;
      S_MUL:  if (flush || mul_last)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ans_d    = ans_q;
    flag_d   = flag_q;
    vld_d    = 1'b0;
    dout_d   = dout_q;
    dm_d     = dm_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (fire) begin
      dm_d = B;
      if (op_dec == OP_MUL) begin
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        prod_d   = '0;
        cnt_d    = '0;
      end else begin
        vld_d = 1'b1;
        if (alu_wr) begin
          ans_d  = alu_res;
          flag_d = alu_flags;
        end
        if (op_dec == OP_OUT) dout_d = A;
      end
    end
    // A flushed multiply freezes here and simply never writes back.
    if (mul_step) begin
      prod_d   = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_ONE;
      if (mul_last) begin
        ans_d  = mul_sum[WIDTH-1:0];
        flag_d = {mul_sum[WIDTH-1], mul_sum[WIDTH-1:0] == '0, 1'b0, |mul_sum[2*WIDTH-1:WIDTH]};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_q    <= '0;
      flag_q   <= '0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
      dm_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      ans_q    <= ans_d;
      flag_q   <= flag_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
      dm_q     <= dm_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ans_ex    = ans_q;
  assign flag_ex   = flag_q;
  assign out_valid = vld_q;
  assign data_out  = dout_q;
  assign DM_data   = dm_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_alu_ex_stage;
  localparam int W = 16;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, MOV = 6'b000010, AND_ = 6'b000100,
                         OR_ = 6'b000101, XOR_ = 6'b000110, NOT_ = 6'b000111, SLL = 6'b011001,
                         SRL = 6'b011010, SRA = 6'b011011, IN_ = 6'b010110, OUT_ = 6'b010111,
                         HOLD = 6'b011100, MUL = 6'b100000, BAD = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_ready, flush, out_valid;
  logic [5:0] op_dec;
  logic [W-1:0] A, B, data_in, ans_ex, data_out, DM_data;
  logic [3:0] flag_ex;

  logic in_valid2, in_ready2, out_valid2;
  logic [5:0] op_dec2;
  logic [31:0] A2, B2, data_in2, ans_ex2, data_out2, DM_data2;
  logic [3:0] flag_ex2;

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op_dec(op_dec),
    .A(A), .B(B), .data_in(data_in), .flush(flush), .ans_ex(ans_ex), .flag_ex(flag_ex),
    .out_valid(out_valid), .data_out(data_out), .DM_data(DM_data));

  alu_ex_stage #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .op_dec(op_dec2),
    .A(A2), .B(B2), .data_in(data_in2), .flush(1'b0), .ans_ex(ans_ex2), .flag_ex(flag_ex2),
    .out_valid(out_valid2), .data_out(data_out2), .DM_data(DM_data2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] ans;
    logic [3:0]   flg;
    bit           upd;
  } res_t;

  // Reference: plain integer arithmetic on the operand values, flags from ranges.
  function automatic res_t model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] din);
    res_t o;
    longint ua = a, ub = b;
    longint sa = $signed(a), sb = $signed(b);
    longint mask = (longint'(1) << W) - 1;
    longint lo = -(longint'(1) << (W-1)), hi = (longint'(1) << (W-1)) - 1;
    int s = int'(ub % W);
    longint r = 0;
    bit c = 0, v = 0, nz = 1;
    o.upd = 1;
    if (op[5:2] == 4'b0111 || op == OUT_) o.upd = 0;
    else begin
      case (op)
        ADD:  begin r = ua + ub; c = (r > mask); v = (sa + sb < lo) || (sa + sb > hi); end
        SUB:  begin r = ua - ub; c = (ua >= ub); v = (sa - sb < lo) || (sa - sb > hi); end
        MOV:  r = ub;
        AND_: r = ua & ub;
        OR_:  r = ua | ub;
        XOR_: r = ua ^ ub;
        NOT_: r = ~ub;
        SLL:  begin r = ua << s; c = (s != 0) && (((ua >> (W - s)) & 1) == 1); end
        SRL:  begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
        SRA:  begin r = sa >>> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
        IN_:  r = din;
        MUL:  begin r = ua * ub; v = (r > mask); end
        default: begin r = 0; nz = 0; end
      endcase
    end
    r = r & mask;
    o.ans = r[W-1:0];
    o.flg = {nz && r[W-1], nz && (r == 0), c, v};
    return o;
  endfunction

  logic [W-1:0] m_ans, m_dout, m_dm;
  logic [3:0]   m_flg;

  task automatic drive(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] din);
    @(negedge clk);
    op_dec = op; A = a; B = b; data_in = din; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] din);
    res_t r;
    int lat;
    r = model(op, a, b, din);
    drive(op, a, b, din);
    if (op == MUL) begin
      lat = 0;
      while (!out_valid && lat < W + 4) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("mul_latency", lat, W);
    end else begin
      chk("rand_out_valid", out_valid, 1'b1);
    end
    m_dm = b;
    if (r.upd) begin m_ans = r.ans; m_flg = r.flg; end
    if (op == OUT_) m_dout = a;
    chk("rand_ans", ans_ex, m_ans);
    chk("rand_flags", flag_ex, m_flg);
    chk("rand_data_out", data_out, m_dout);
    chk("rand_dm_data", DM_data, m_dm);
    @(posedge clk);
    #1;
    chk("rand_strobe_width", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a, b, din, ans;
    logic [3:0]   flg;
  } vec_t;

  localparam logic [5:0] OPS [15] = '{ADD, SUB, MOV, AND_, OR_, XOR_, NOT_, SLL, SRL, SRA,
                                      IN_, OUT_, 6'b011111, MUL, BAD};

  initial begin
    vec_t vecs [15];
    int low_cnt, bad;
    logic [5:0] op;

    vecs[0]  = '{ADD,  16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 4'b1001};
    vecs[1]  = '{SUB,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0110};
    vecs[2]  = '{SUB,  16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 4'b1000};
    vecs[3]  = '{SRA,  16'h8000, 16'h0003, 16'h0000, 16'hF000, 4'b1000};
    vecs[4]  = '{SLL,  16'h8001, 16'h0001, 16'h0000, 16'h0002, 4'b0010};
    vecs[5]  = '{AND_, 16'hF0F0, 16'hFF00, 16'h0000, 16'hF000, 4'b1000};
    vecs[6]  = '{OR_,  16'h00F0, 16'h0F00, 16'h0000, 16'h0FF0, 4'b0000};
    vecs[7]  = '{XOR_, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100};
    vecs[8]  = '{NOT_, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 4'b0100};
    vecs[9]  = '{MOV,  16'h0001, 16'h8000, 16'h0000, 16'h8000, 4'b1000};
    vecs[10] = '{IN_,  16'h0001, 16'h0002, 16'h00C3, 16'h00C3, 4'b0000};
    vecs[11] = '{SRL,  16'h0003, 16'h0001, 16'h0000, 16'h0001, 4'b0010};
    vecs[12] = '{BAD,  16'h0001, 16'h0001, 16'h0000, 16'h0000, 4'b0000};
    vecs[13] = '{SLL,  16'h8000, 16'h0010, 16'h0000, 16'h8000, 4'b1000};
    vecs[14] = '{ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0110};

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; op_dec = '0; A = '0; B = '0; data_in = '0;
    in_valid2 = 1'b0; op_dec2 = '0; A2 = '0; B2 = '0; data_in2 = '0;
    #2;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_ans", ans_ex, 16'h0);
    chk("reset_flags", flag_ex, 4'h0);
    chk("reset_data_out", data_out, 16'h0);
    chk("reset_dm_data", DM_data, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].din);
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_ans", i), ans_ex, vecs[i].ans);
      chk($sformatf("vec%0d_flags", i), flag_ex, vecs[i].flg);
      chk($sformatf("vec%0d_dm", i), DM_data, vecs[i].b);
    end

    // ADD, HOLD, OUT
    drive(ADD, 16'h0003, 16'h0004, 16'h0);
    chk("add7_ans", ans_ex, 16'h0007);
    chk("add7_flags", flag_ex, 4'b0000);
    drive(HOLD, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk("hold_out_valid", out_valid, 1'b1);
    chk("hold_ans", ans_ex, 16'h0007);
    chk("hold_flags", flag_ex, 4'b0000);
    drive(OUT_, 16'h1234, 16'h5678, 16'h0);
    chk("out_data_out", data_out, 16'h1234);
    chk("out_dm_data", DM_data, 16'h5678);
    chk("out_ans", ans_ex, 16'h0007);
    @(posedge clk);
    #1;
    chk("out_strobe_width", out_valid, 1'b0);

    // MUL 0100*0100 with an ADD offered mid-multiply
    drive(MUL, 16'h0100, 16'h0100, 16'h0);
    low_cnt = (in_ready == 1'b0) ? 1 : 0;
    bad = (out_valid == 1'b1) ? 1 : 0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin op_dec = ADD; A = 16'h0001; B = 16'h0001; in_valid = 1'b1; end
      if (i == 3) in_valid = 1'b0;
      if (i < W) begin
        if (!in_ready) low_cnt++;
        if (out_valid) bad++;
      end
    end
    chk("mul_busy_cycles", low_cnt, W);
    chk("mul_early_strobe", bad, 0);
    chk("mul_out_valid", out_valid, 1'b1);
    chk("mul_ans", ans_ex, 16'h0000);
    chk("mul_flags", flag_ex, 4'b0101);
    chk("mul_ready_after", in_ready, 1'b1);
    chk("mul_dm_data", DM_data, 16'h0100);
    @(posedge clk);
    #1;
    chk("mul_no_queued_add", out_valid, 1'b0);
    chk("mul_ans_kept", ans_ex, 16'h0000);

    // flush at cycle 5 of a multiply
    drive(ADD, 16'h0003, 16'h0004, 16'h0);
    drive(MUL, 16'h0003, 16'h0005, 16'h0);
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1'b1);
    bad = 0;
    for (int i = 0; i <= W; i++) begin
      if (out_valid) bad++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_strobe", bad, 0);
    chk("flush_ans_kept", ans_ex, 16'h0007);
    chk("flush_flags_kept", flag_ex, 4'b0000);
    flush = 1'b1;
    drive(ADD, 16'h0001, 16'h0001, 16'h0);
    flush = 1'b0;
    chk("idle_flush_out_valid", out_valid, 1'b1);
    chk("idle_flush_ans", ans_ex, 16'h0002);

    // reset at cycle 5 of a multiply
    drive(MUL, 16'h00FF, 16'h0101, 16'h0);
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("mreset_in_ready", in_ready, 1'b1);
    chk("mreset_out_valid", out_valid, 1'b0);
    chk("mreset_ans", ans_ex, 16'h0);
    chk("mreset_flags", flag_ex, 4'h0);
    chk("mreset_data_out", data_out, 16'h0);
    chk("mreset_dm", DM_data, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    op_dec = ADD; A = 16'h0001; B = 16'h0002; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_reset_accept", out_valid, 1'b1);
    chk("post_reset_ans", ans_ex, 16'h0003);
    bad = 0;
    for (int i = 0; i <= W + 2; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("post_reset_mul_discarded", bad, 0);

    // random ops against the model
    m_ans = 16'h0003; m_flg = 4'b0000; m_dout = 16'h0; m_dm = 16'h0002;
    for (int n = 0; n < 120; n++) begin
      op = OPS[$urandom_range(0, 14)];
      run_op(op, W'($urandom), W'($urandom), W'($urandom));
    end

    // 32-bit instance
    @(negedge clk);
    op_dec2 = ADD; A2 = 32'h7FFFFFFF; B2 = 32'h00000001; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    chk("w32_out_valid", out_valid2, 1'b1);
    chk("w32_ans", ans_ex2, 32'h80000000);
    chk("w32_flags", flag_ex2, 4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
